// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Optional macro ALU_SHARE_FIXED_PRIO_EN selects fixed priority (req0 wins) instead of round-robin.
module alu_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,

    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_r,

    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_owner;

    logic             w_idle;
    logic             w_win;
    logic             w_accept;
    logic             w_resp_hs;

    // Ready is forced low while reset is asserted, not just after the state settles.
    assign w_idle = (r_state == S_IDLE) && !reset;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign w_win = !req0_valid;
`else
    logic r_last_grant;

    assign w_win = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_win;
        end
    end
`endif

    assign w_accept   = w_idle && (req0_valid || req1_valid);
    assign req0_ready = w_idle && req0_valid && !w_win;
    assign req1_ready = w_idle && req1_valid && w_win;
    assign w_resp_hs  = (r_state == S_RESP) && (r_owner ? resp1_ready : resp0_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_owner  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_win ? req1_op : req0_op;
                        r_a     <= w_win ? req1_a  : req0_a;
                        r_b     <= w_win ? req1_b  : req0_b;
                        r_owner <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_r;
                    r_zero   <= (alu_r == '0);
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU inputs come only from the operand registers, so they never follow requester inputs.
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_op      = r_op;
    assign resp_result = r_result;
    assign resp_zero   = r_zero;
    assign resp0_valid = (r_state == S_RESP) && !r_owner;
    assign resp1_valid = (r_state == S_RESP) && r_owner;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: accepts push expected results, a monitor pops on response handshakes.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [2:0]  alu_op;
    logic        busy;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_res [2];
    logic        exp_zero[2];
    int          checks   = 0;
    int          failures = 0;

    alu_share_ctrl #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared ALU
    always_comb begin
        case (alu_op)
            3'd0:    alu_r = alu_a & alu_b;
            3'd1:    alu_r = alu_a | alu_b;
            3'd2:    alu_r = ~(alu_a | alu_b);
            3'd3:    alu_r = alu_a + alu_b;
            3'd4:    alu_r = alu_a - alu_b;
            3'd5:    alu_r = alu_a ^ alu_b;
            default: alu_r = alu_a;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Accept side: push the expected response for whichever requester was granted.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) sb.push_back('{0, exp_res[0], exp_zero[0]});
            if (req1_valid && req1_ready) sb.push_back('{1, exp_res[1], exp_zero[1]});
        end
    end

    // Response side: compare on every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (resp0_valid && resp1_valid) chk("resp_both_valid", 1, 0);
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner",  {31'd0, resp1_valid}, e.id);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_zero",   {31'd0, resp_zero}, {31'd0, e.z});
                end
            end
        end
    end

    task automatic set_req(input int k, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic ez);
        exp_res[k]  = er;
        exp_zero[k] = ez;
        if (k == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
    endtask

    task automatic run_single(input int k, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic ez);
        @(posedge clk); #1;
        set_req(k, op, a, b, er, ez);
        @(negedge clk);
        chk("accept_ready", (k == 0) ? req0_ready : req1_ready, 1);
        chk("accept_other_ready", (k == 0) ? req1_ready : req0_ready, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_op", alu_op, op);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_busy", busy, 1);
        chk("exec_no_valid", resp0_valid | resp1_valid, 0);
        @(negedge clk);
        chk("resp_valid_own", (k == 0) ? resp0_valid : resp1_valid, 1);
        chk("resp_valid_other", (k == 0) ? resp1_valid : resp0_valid, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
        chk({tag, "_resp_valid"}, {resp1_valid, resp0_valid}, 0);
        chk({tag, "_result"}, resp_result, 0);
        chk({tag, "_zero"}, resp_zero, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[$];
        int gcy[$];
        int exp_g[4];
`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        exp_res = '{32'd0, 32'd0};
        exp_zero = '{1'b0, 1'b0};

        // Reset state, with a request present to prove ready stays low
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_single(0, 3'b010, 32'hFFFF_FFFF, 32'h40A0_0400, 32'h0000_0000, 1'b1);
        run_single(1, 3'b010, 32'h2222_0225, 32'hC242_0423, 32'h1D9D_F9D8, 1'b0);

        // Both requesters valid continuously
        @(posedge clk); #1;
        set_req(0, 3'd3, 32'd1, 32'd2, 32'd3, 1'b0);
        set_req(1, 3'd4, 32'd5, 32'd5, 32'd0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("rr_one_ready", req0_ready & req1_ready, 0);
            if (req0_ready) begin gid.push_back(0); gcy.push_back(c); end
            else if (req1_ready) begin gid.push_back(1); gcy.push_back(c); end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", gid.size(), 4);
        for (int j = 0; j < gid.size() && j < 4; j++) begin
            chk("rr_grant", gid[j], exp_g[j]);
            if (j > 0) chk("rr_spacing", gcy[j] - gcy[j-1], 3);
        end

        run_single(0, 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
        run_single(1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        run_single(0, 3'd4, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
        run_single(1, 3'd5, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0);

        // Response stall with req1 waiting and a stray resp1_ready pulse
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(posedge clk); #1;
        set_req(0, 3'd3, 32'h10, 32'h20, 32'h30, 1'b0);
        @(negedge clk);
        chk("stall_accept", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        set_req(1, 3'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        @(negedge clk);
        chk("stall_exec_req1_ready", req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp0_valid", resp0_valid, 1);
            chk("stall_resp1_valid", resp1_valid, 0);
            chk("stall_result", resp_result, 32'h30);
            chk("stall_ready", {req1_ready, req0_ready}, 0);
            chk("stall_busy", busy, 1);
            resp1_ready = (i == 1);
        end
        @(posedge clk); #1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        @(negedge clk);
        chk("hs_cycle_req1_ready", req1_ready, 0);
        @(negedge clk);
        chk("after_hs_resp0_valid", resp0_valid, 0);
        chk("after_hs_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted during EXEC
        @(posedge clk); #1;
        set_req(1, 3'd0, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'hDEAD_0000, 1'b0);
        @(negedge clk);
        chk("rexec_accept", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("rexec_in_exec", busy, 1);
        #2;
        reset = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk_reset_vals("rexec");
        sb.delete();
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rexec_no_resp", {resp1_valid, resp0_valid}, 0);
        end
        run_single(0, 3'd3, 32'd7, 32'd8, 32'd15, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitrating sequencer that shares one combinational 32-bit ALU/logic unit (and, or, nor, add, sub, …) between two requesters, e.g. execute stage and address-compute path. Each requester issues one operation with valid/ready; the controller grants one, drives the shared ALU from registered operands, captures the result and returns it over a held response handshake. One operation is in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width (passed through untouched)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  input  1  rising-edge clock
  - reset  input  1  asynchronous, active-high reset
- Requester k (k = 0, 1):
  - reqk_valid  input  1  request present
  - reqk_ready  output  1  request accepted this cycle when high with reqk_valid
  - reqk_op  input  OPW  ALU opcode
  - reqk_a, reqk_b  input  WIDTH  operands
- Response k (k = 0, 1):
  - respk_valid  output  1  result for requester k available
  - respk_ready  input  1  requester k consumes result
- Shared result and ALU side:
  - resp_result  output  WIDTH  captured ALU result, shared by both responses
  - resp_zero  output  1  resp_result == 0
  - alu_a, alu_b  output  WIDTH  operands to the shared ALU
  - alu_op  output  OPW  opcode to the shared ALU
  - alu_r  input  WIDTH  combinational ALU result
- busy  output  1  state != IDLE

## Operation
- State machine:
  - IDLE: wait for a request.
  - EXEC: drive the ALU, capture its result.
  - RESP: present the result to the granted requester.
- IDLE:
  - reqk_ready is high only for the arbitration winner among the valid requesters; the loser's ready stays 0. Ready may depend combinationally on valid.
  - On accept (valid & ready): latch op/a/b into operand registers, record grant id in `owner`, go to EXEC.
- EXEC, exactly one cycle:
  - alu_a/alu_b/alu_op are driven from the operand registers.
  - At the clock edge: capture alu_r into resp_result, capture zero flag into resp_zero, go to RESP.
- RESP:
  - resp_owner_valid = 1; the other respk_valid stays 0.
  - Hold result and flag stable until resp_owner_ready = 1.
  - On that edge go to IDLE.
  - Both reqk_ready are 0 in EXEC and RESP.
- Outside EXEC, alu_a/alu_b/alu_op keep the last operand-register values; no glitching to requester inputs.
- Arbitration, default round-robin:
  - Register last_grant.
  - Both requesters valid: the requester ≠ last_grant wins.
  - Single requester valid: it wins.
  - last_grant updates on accept.
  - Reset value of last_grant is 1, so req0 wins the first contention.
- A requester may hold valid while its response is pending; its next request is arbitrated only after return to IDLE.
- A respk_ready seen while respk_valid = 0 is ignored.

## Timing
- Accept in cycle N → EXEC in N+1 → respk_valid high from N+2.
- Minimum accept-to-accept spacing is 3 cycles, when respk_ready is high in N+2.
- Back-to-back: a new accept is possible in the cycle after the RESP handshake (N+3), not in the handshake cycle itself.
- Reset, asynchronous, takes effect immediately, including mid-EXEC or mid-RESP; any in-flight operation is dropped with no response. Reset values:
  - state = IDLE
  - req0_ready, req1_ready = 0 while reset is high
  - resp0_valid, resp1_valid = 0
  - resp_result = 0, resp_zero = 0
  - alu_a = 0, alu_b = 0, alu_op = 0
  - owner = 0, last_grant = 1, busy = 0
- First accept is possible in the first clock edge after reset deasserts.

## Configuration
- ALU_SHARE_FIXED_PRIO_EN:
  - Defined: fixed priority; req0 always wins when both are valid, and last_grant is not used.
  - Undefined (default): round-robin as described above.
- All other behaviour, latency and reset values are identical in both builds.

## Test plan
- Reset, then req0: op=3'b010 (NOR), a=32'hFFFF_FFFF, b=32'h40A0_0400, with resp0_ready=1 → req0_ready=1 in N, alu_op=3'b010 in N+1, resp0_valid=1 in N+2, resp_result=32'h0000_0000, resp_zero=1, resp1_valid=0.
- req1: NOR, a=32'h2222_0225, b=32'hC242_0423 → resp1_valid at N+2, resp_result=32'h1D9D_F9D8, resp_zero=0.
- Both valid continuously, responses ready → grants alternate 0,1,0,1 with one accept every 3 cycles. With ALU_SHARE_FIXED_PRIO_EN, grants are 0,0,0,0.
- Hold resp0_ready=0 for 5 cycles in RESP → resp0_valid and resp_result stable, both reqk_ready=0, busy=1; result drops one cycle after resp0_ready rises.
- Assert reset during EXEC → outputs go to reset values immediately; no respk_valid after release; next request completes normally with N+2 latency.
- resp1_ready pulsed while owner=0 → no effect; resp0_valid still held.
